// File: rtl/wb_queue.sv
// Writeback queue: strict FIFO of {addr, data} results draining into register-file port 3.
// Optional lookup/forwarding of pending writes is enabled by defining WBQ_BYPASS_EN.
module wb_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [4:0]    IN_ADDR,
  input  logic [31:0]   IN_DATA,
  input  logic          HOLD,
  output logic [4:0]    A3,
  output logic          WE3,
  output logic [31:0]   WD3,
  output logic [CW-1:0] COUNT
`ifdef WBQ_BYPASS_EN
  ,
  input  logic [4:0]    Q1,
  input  logic [4:0]    Q2,
  output logic          HIT1,
  output logic          HIT2,
  output logic [31:0]   FWD1,
  output logic [31:0]   FWD2
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, not_empty;

  // Handshake: a result transfers on a posedge where IN_VALID and IN_READY are both 1;
  // IN_READY looks only at registered occupancy, never at a same-cycle drain.
  assign not_empty = (count_q != '0);
  assign IN_READY  = (count_q < DEPTH_C) & ~RESET;
  assign WE3       = not_empty & ~HOLD & ~RESET;
  assign push      = IN_VALID & IN_READY;
  assign pop       = WE3;
  assign COUNT     = count_q;
  assign A3        = (not_empty & ~RESET) ? addr_mem[rd_ptr_q] : 5'd0;
  assign WD3       = (not_empty & ~RESET) ? data_mem[rd_ptr_q] : 32'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; outputs mask it whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= IN_ADDR;
      data_mem[wr_ptr_q] <= IN_DATA;
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match wins; the head stays visible while draining.
  function automatic logic [32:0] lookup(input logic [4:0] q);
    logic [32:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem[idx] == q)) res = {1'b1, data_mem[idx]};
    end
    return res;
  endfunction

  assign {HIT1, FWD1} = lookup(Q1);
  assign {HIT2, FWD2} = lookup(Q2);
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue (DEPTH=4): fixed vector table, directed sequences, then random traffic
// against a queue-based reference; lookup checks compile in when WBQ_BYPASS_EN is defined.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET, IN_VALID, HOLD;
  logic          IN_READY, WE3;
  logic [4:0]    IN_ADDR, A3;
  logic [31:0]   IN_DATA, WD3;
  logic [CW-1:0] COUNT;
`ifdef WBQ_BYPASS_EN
  logic [4:0]    Q1, Q2;
  logic          HIT1, HIT2;
  logic [31:0]   FWD1, FWD2;
`endif

  int total = 0;
  int bad = 0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .HOLD(HOLD),
    .A3(A3), .WE3(WE3), .WD3(WD3), .COUNT(COUNT)
`ifdef WBQ_BYPASS_EN
    , .Q1(Q1), .Q2(Q2), .HIT1(HIT1), .HIT2(HIT2), .FWD1(FWD1), .FWD2(FWD2)
`endif
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // scoreboard: pending {addr, data} entries, head at index 0
  logic [36:0] exp_q[$];

  typedef struct {
    logic v; logic [4:0] a; logic [31:0] d; logic h; logic r;
    logic rdy; logic we; logic [4:0] ea; logic [31:0] ed; logic [CW-1:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h,
                     input logic r, input logic rdy, input logic we, input logic [4:0] ea,
                     input logic [31:0] ed, input int cnt);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.h = h; t.r = r;
    t.rdy = rdy; t.we = we; t.ea = ea; t.ed = ed; t.cnt = CW'(cnt);
    tbl.push_back(t);
  endtask

  // driver: called at posedge+1, checks at posedge+2, returns at next posedge+1
  task automatic model_cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                             input logic h, input logic r);
    int n;
    logic er, ew;
    logic [4:0] ea;
    logic [31:0] ed;
    IN_VALID = v; IN_ADDR = a; IN_DATA = d; HOLD = h; RESET = r;
`ifdef WBQ_BYPASS_EN
    Q1 = 5'($urandom_range(0, 7));
    Q2 = 5'($urandom_range(0, 31));
`endif
    #1;
    n  = exp_q.size();
    er = (n < DEPTH) && !r;
    ew = (n > 0) && !h && !r;
    ea = (n > 0 && !r) ? exp_q[0][36:32] : 5'd0;
    ed = (n > 0 && !r) ? exp_q[0][31:0] : 32'd0;
    check("in_ready", 32'(IN_READY), 32'(er));
    check("we3", 32'(WE3), 32'(ew));
    check("a3", 32'(A3), 32'(ea));
    check("wd3", WD3, ed);
    check("count", 32'(COUNT), 32'(n));
`ifdef WBQ_BYPASS_EN
    begin
      logic h1, h2;
      logic [31:0] f1, f2;
      h1 = 0; h2 = 0; f1 = 0; f2 = 0;
      foreach (exp_q[k]) begin
        if (exp_q[k][36:32] == Q1) begin h1 = 1; f1 = exp_q[k][31:0]; end
        if (exp_q[k][36:32] == Q2) begin h2 = 1; f2 = exp_q[k][31:0]; end
      end
      check("hit1", 32'(HIT1), 32'(h1));
      check("fwd1", FWD1, f1);
      check("hit2", 32'(HIT2), 32'(h2));
      check("fwd2", FWD2, f2);
    end
`endif
    @(posedge CLK);
    if (r) exp_q.delete();
    else begin
      if (ew) void'(exp_q.pop_front());
      if (v && er) exp_q.push_back({a, d});
    end
    #1;
  endtask

  initial begin
    RESET = 1; IN_VALID = 0; IN_ADDR = 0; IN_DATA = 0; HOLD = 0;
`ifdef WBQ_BYPASS_EN
    Q1 = 0; Q2 = 0;
`endif
    repeat (2) @(posedge CLK);
    #1;

    // v  a   d             h  r | rdy we ea  ed            cnt
    add(1, 3,  32'h0,        0, 1,  0,  0, 0,  32'h0,        0);
    add(1, 3,  32'hDEADBEEF, 0, 0,  1,  0, 0,  32'h0,        0);
    add(0, 0,  32'h0,        0, 0,  1,  1, 3,  32'hDEADBEEF, 1);
    add(0, 0,  32'h0,        0, 0,  1,  0, 0,  32'h0,        0);
    add(1, 10, 32'd100,      1, 0,  1,  0, 0,  32'h0,        0);
    add(1, 11, 32'd101,      1, 0,  1,  0, 10, 32'd100,      1);
    add(1, 12, 32'd102,      1, 0,  1,  0, 10, 32'd100,      2);
    add(1, 13, 32'd103,      1, 0,  1,  0, 10, 32'd100,      3);
    add(1, 14, 32'd104,      1, 0,  0,  0, 10, 32'd100,      4);
    add(1, 14, 32'd104,      0, 0,  0,  1, 10, 32'd100,      4);
    add(1, 14, 32'd104,      0, 0,  1,  1, 11, 32'd101,      3);
    add(0, 0,  32'h0,        0, 0,  1,  1, 12, 32'd102,      3);
    add(0, 0,  32'h0,        0, 0,  1,  1, 13, 32'd103,      2);
    add(0, 0,  32'h0,        0, 0,  1,  1, 14, 32'd104,      1);
    add(0, 0,  32'h0,        0, 0,  1,  0, 0,  32'h0,        0);
    add(1, 0,  32'd1,        1, 0,  1,  0, 0,  32'h0,        0);
    add(1, 2,  32'd2,        1, 0,  1,  0, 0,  32'd1,        1);
    add(1, 3,  32'd3,        0, 0,  1,  1, 0,  32'd1,        2);
    add(0, 0,  32'h0,        1, 0,  1,  0, 2,  32'd2,        2);
    add(0, 0,  32'h0,        0, 1,  0,  0, 0,  32'h0,        2);
    add(0, 0,  32'h0,        0, 0,  1,  0, 0,  32'h0,        0);
    add(1, 7,  32'd70,       1, 0,  1,  0, 0,  32'h0,        0);
    add(1, 31, 32'd80,       1, 0,  1,  0, 7,  32'd70,       1);
    add(1, 9,  32'd90,       1, 0,  1,  0, 7,  32'd70,       2);
    add(0, 0,  32'h0,        0, 0,  1,  1, 7,  32'd70,       3);
    add(0, 0,  32'h0,        0, 1,  0,  0, 0,  32'h0,        2);
    add(0, 0,  32'h0,        0, 0,  1,  0, 0,  32'h0,        0);

    foreach (tbl[i]) begin
      IN_VALID = tbl[i].v; IN_ADDR = tbl[i].a; IN_DATA = tbl[i].d;
      HOLD = tbl[i].h; RESET = tbl[i].r;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(IN_READY), 32'(tbl[i].rdy));
      check($sformatf("vec%0d_we3", i), 32'(WE3), 32'(tbl[i].we));
      check($sformatf("vec%0d_a3", i), 32'(A3), 32'(tbl[i].ea));
      check($sformatf("vec%0d_wd3", i), WD3, tbl[i].ed);
      check($sformatf("vec%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
      @(posedge CLK);
      #1;
    end
    exp_q.delete();

    // continuous push with no hold, addresses 0..7 repeating, across pointer wrap
    for (int i = 0; i < 11; i++) model_cycle(1, 5'(i % 8), $urandom, 0, 0);
    model_cycle(0, 0, 0, 0, 0);
    model_cycle(0, 0, 0, 0, 0);

`ifdef WBQ_BYPASS_EN
    model_cycle(0, 0, 0, 0, 1);
    model_cycle(1, 2, 32'h11, 1, 0);
    model_cycle(1, 2, 32'h22, 1, 0);
    Q1 = 2; Q2 = 4;
    #1;
    check("byp_hit1", 32'(HIT1), 32'd1);
    check("byp_fwd1", FWD1, 32'h22);
    check("byp_hit2", 32'(HIT2), 32'd0);
    check("byp_fwd2", FWD2, 32'd0);
`endif

    // random traffic against the reference queue
    for (int i = 0; i < 600; i++) begin
      logic v, h, r;
      logic [4:0] a;
      v = ($urandom_range(0, 99) < 70);
      h = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      model_cycle(v, a, $urandom, h, r);
    end
    for (int i = 0; i < DEPTH + 1; i++) model_cycle(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued writeback entries; SHALL be a power of two in 2..16.
REQ-002 Port: CLK  input  1  sole clock; all state SHALL update on posedge CLK.
REQ-003 Port: RESET  input  1  reset, synchronous, active-high.
REQ-004 Port: IN_VALID  input  1  execute stage offers a result this cycle.
REQ-005 Port: IN_READY  output  1  queue accepts the offered result this cycle.
REQ-006 Port: IN_ADDR  input  5  destination register of offered result.
REQ-007 Port: IN_DATA  input  32  result value.
REQ-008 Port: HOLD  input  1  suppress draining this cycle.
REQ-009 Port: A3  output  5  register-file write address, drives register-file A3.
REQ-010 Port: WE3  output  1  register-file write enable, drives register-file WE3.
REQ-011 Port: WD3  output  32  register-file write data, drives register-file WD3.
REQ-012 Port: COUNT  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 Port (WBQ_BYPASS_EN only): Q1, Q2  input  5 each  lookup addresses, wired in parallel with register-file A1/A2.
REQ-014 Port (WBQ_BYPASS_EN only): HIT1, HIT2  output  1 each  pending write exists for Q1/Q2.
REQ-015 Port (WBQ_BYPASS_EN only): FWD1, FWD2  output  32 each  pending data for Q1/Q2.

Function
REQ-016 Block SHALL be a strict FIFO of {addr, data} pairs; drain order SHALL equal accept order.
REQ-017 Push SHALL occur at posedge when IN_VALID & IN_READY; IN_VALID without IN_READY SHALL leave state unchanged.
REQ-018 IN_READY SHALL be (COUNT < DEPTH) & ~RESET; it SHALL NOT depend on same-cycle drain, so a full queue stays unready even while draining.
REQ-019 WE3 SHALL be (COUNT != 0) & ~HOLD & ~RESET, combinational from registered state.
REQ-020 A3/WD3 SHALL present the head entry when COUNT != 0, else 5'd0 / 32'd0.
REQ-021 Pop SHALL occur at posedge when WE3 = 1; the register file commits the same edge.
REQ-022 Latency: entry pushed at edge N SHALL be presented with WE3 = 1 in the cycle following edge N (committed at edge N+1) if it is head and HOLD = 0.
REQ-023 Simultaneous push and pop SHALL leave COUNT unchanged; from empty, no same-cycle pass-through.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH nor underflow.
REQ-025 IN_ADDR SHALL pass unmodified to A3, including address 0 and addresses with bits [4:3] nonzero.
REQ-026 HOLD SHALL only freeze draining; pushes SHALL continue while not full.

Reset
REQ-027 RESET high at posedge SHALL set COUNT = 0 and both pointers = 0, discarding all entries.
REQ-028 While RESET is high: WE3 = 0, IN_READY = 0, A3 = 0, WD3 = 0, and no register-file write SHALL issue.
REQ-029 First cycle after RESET deasserts: IN_READY = 1, WE3 = 0, COUNT = 0.
REQ-030 Entry storage need not be cleared; stale data SHALL never be observable on outputs.

Configuration
REQ-031 Macro WBQ_BYPASS_EN defined: HITn SHALL be 1 iff any occupied entry (including the head being drained this cycle) has addr == Qn; FWDn SHALL be the youngest matching entry's data, else 32'd0; the entry being pushed this cycle SHALL NOT be visible.
REQ-032 Macro WBQ_BYPASS_EN undefined: Q1, Q2, HIT1, HIT2, FWD1, FWD2 and all comparators SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, then push (3, 32'hDEADBEEF) at edge 1 -> cycle after edge 1: WE3 = 1, A3 = 3, WD3 = DEADBEEF; after edge 2: COUNT = 0, WE3 = 0.
REQ-034 HOLD = 1, push 5 results with DEPTH = 4 -> 4 accepted, IN_READY = 0 with COUNT = 4, 5th held by source; release HOLD -> 4 writes in push order on consecutive cycles, then the 5th.
REQ-035 Continuous push with HOLD = 0 for 10 cycles, addresses 0..7 repeating -> COUNT stays 1, every value written exactly once, in order, across pointer wrap.
REQ-036 Fill 3 entries, assert RESET for one edge mid-drain -> no WE3 during or after reset, COUNT = 0, IN_READY = 1 next cycle.
REQ-037 (WBQ_BYPASS_EN) HOLD = 1, push (2, 32'h11) then (2, 32'h22), Q1 = 2, Q2 = 4 -> HIT1 = 1, FWD1 = 32'h22, HIT2 = 0, FWD2 = 0.
REQ-038 Simultaneous push and pop at COUNT = 2 -> COUNT stays 2; at COUNT = DEPTH with HOLD = 0 -> IN_READY = 0, COUNT drops to DEPTH-1.
